asm_frame_sync: RTL and testbench

Sits directly downstream of the viterbi decoder and consumes its hard-decision bit stream (vit_desc qualified by valid_out_vit). It searches for the CCSDS attached sync marker (ASM) and resolves the 180° phase ambiguity by also matching the inverted marker. Once a marker is found it packs the following bits into bytes, MSB first, and emits one framed CADU payload per marker. A flywheel holds lock across occasional corrupted markers.

---
 rtl/asm_frame_sync.sv | 203 ++++++++++++++++++++
 tb/tb_asm_frame_sync.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asm_frame_sync.sv
// asm_frame_sync: CCSDS attached-sync-marker search, polarity resolution and CADU byte framing with flywheel lock.
// Latency: byte_out/byte_valid are registered 1 clk after the valid cycle of the byte's 8th bit.
// Backpressure: none; a bit is consumed on every bit_valid cycle, with any gap between valid cycles allowed.
// Ports: clk, sys_rst (sync, active high); bit_in/bit_valid from the viterbi decoder;
//        byte_out/byte_valid/sof/eof payload stream; locked, inverted, frame_count, asm_err status.
module asm_frame_sync #(
  parameter logic [31:0] ASM         = 32'h1ACFFC1D,
  parameter int          FRAME_BYTES = 1020,
  parameter int          MAX_ERR     = 2,
  parameter int          LOCK_MISS   = 3
) (
  input  logic        clk,
  input  logic        sys_rst,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic        sof,
  output logic        eof,
  output logic        locked,
  output logic        inverted,
  output logic [15:0] frame_count,
  output logic [5:0]  asm_err
);

  localparam int             BCW       = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int             MCW       = $clog2(LOCK_MISS + 1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(FRAME_BYTES - 1);
  localparam logic [5:0]     ERR_LIM   = 6'(MAX_ERR);
  localparam logic [MCW-1:0] MISS_LIM  = MCW'(LOCK_MISS);

  typedef enum logic [1:0] {S_SEARCH, S_FRAME, S_CHECK} state_t;

  state_t          state_q, state_d;
  logic [31:0]     sr_q, sr_d;
  logic [5:0]      fill_q, fill_d;       // bits seen since entering SEARCH, saturates at 32
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [BCW-1:0]  byte_cnt_q, byte_cnt_d;
  logic [4:0]      mk_cnt_q, mk_cnt_d;
  logic [MCW-1:0]  miss_q, miss_d;
  logic [7:0]      acc_q, acc_d;
  logic [7:0]      byte_out_q, byte_out_d;
  logic            byte_valid_q, byte_valid_d;
  logic            sof_q, sof_d;
  logic            eof_q, eof_d;
  logic            locked_q, locked_d;
  logic            inverted_q, inverted_d;
  logic [15:0]     frame_count_q, frame_count_d;
  logic [5:0]      asm_err_q, asm_err_d;
  logic [5:0]      dist_p, dist_n, dist_sel;

  function automatic logic [5:0] popcnt32(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + {5'd0, v[i]};
    return n;
  endfunction

  // Marker distances are taken on the post-shift register so a match is
  // recognised on the same edge that accepts the marker's last bit.
  always_comb begin
    sr_d = bit_valid ? {sr_q[30:0], bit_in} : sr_q;
  end

  always_comb begin
    dist_p   = popcnt32(sr_d ^ ASM);
    dist_n   = popcnt32(sr_d ^ ~ASM);
    dist_sel = inverted_q ? dist_n : dist_p;
  end

  always_comb begin
    state_d       = state_q;
    fill_d        = fill_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    mk_cnt_d      = mk_cnt_q;
    miss_d        = miss_q;
    acc_d         = acc_q;
    byte_out_d    = byte_out_q;
    byte_valid_d  = 1'b0;
    sof_d         = 1'b0;
    eof_d         = 1'b0;
    inverted_d    = inverted_q;
    frame_count_d = frame_count_q;
    asm_err_d     = asm_err_q;

    if (bit_valid) begin
      unique case (state_q)
        S_SEARCH: begin
          if (fill_q != 6'd32) fill_d = fill_q + 6'd1;
          // fill_q >= 31 means this bit completes at least 32 fresh bits
          if (fill_q >= 6'd31) begin
            if (dist_p <= ERR_LIM) begin
              state_d    = S_FRAME;
              inverted_d = 1'b0;
              asm_err_d  = dist_p;
              miss_d     = '0;
            end else if (dist_n <= ERR_LIM) begin
              state_d    = S_FRAME;
              inverted_d = 1'b1;
              asm_err_d  = dist_n;
              miss_d     = '0;
            end
          end
        end
        S_FRAME: begin
          acc_d     = {acc_q[6:0], bit_in ^ inverted_q};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_out_d   = acc_d;
            byte_valid_d = 1'b1;
            sof_d        = (byte_cnt_q == '0);
            eof_d        = (byte_cnt_q == LAST_BYTE);
            if (byte_cnt_q == LAST_BYTE) begin
              frame_count_d = frame_count_q + 16'd1;
              state_d       = S_CHECK;
            end else begin
              byte_cnt_d = byte_cnt_q + 1'b1;
            end
          end
        end
        S_CHECK: begin
          mk_cnt_d = mk_cnt_q + 5'd1;
          if (mk_cnt_q == 5'd31) begin
            asm_err_d = dist_sel;
            if (dist_sel <= ERR_LIM) begin
              miss_d  = '0;
              state_d = S_FRAME;
            end else if (miss_q + 1'b1 == MISS_LIM) begin
              // lock lost: hunt again from scratch in both polarities
              miss_d     = '0;
              inverted_d = 1'b0;
              state_d    = S_SEARCH;
            end else begin
              // flywheel: trust the frame timing and keep emitting
              miss_d  = miss_q + 1'b1;
              state_d = S_FRAME;
            end
          end
        end
        default: state_d = S_SEARCH;
      endcase
    end

    // every state entry starts its counters from zero
    if (state_d != state_q) begin
      fill_d     = '0;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      mk_cnt_d   = '0;
    end

    locked_d = (state_d != S_SEARCH);
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q       <= S_SEARCH;
      sr_q          <= '0;
      fill_q        <= '0;
      bit_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      mk_cnt_q      <= '0;
      miss_q        <= '0;
      acc_q         <= '0;
      byte_out_q    <= '0;
      byte_valid_q  <= 1'b0;
      sof_q         <= 1'b0;
      eof_q         <= 1'b0;
      locked_q      <= 1'b0;
      inverted_q    <= 1'b0;
      frame_count_q <= '0;
      asm_err_q     <= '0;
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      fill_q        <= fill_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      mk_cnt_q      <= mk_cnt_d;
      miss_q        <= miss_d;
      acc_q         <= acc_d;
      byte_out_q    <= byte_out_d;
      byte_valid_q  <= byte_valid_d;
      sof_q         <= sof_d;
      eof_q         <= eof_d;
      locked_q      <= locked_d;
      inverted_q    <= inverted_d;
      frame_count_q <= frame_count_d;
      asm_err_q     <= asm_err_d;
    end
  end

  assign byte_out    = byte_out_q;
  assign byte_valid  = byte_valid_q;
  assign sof         = sof_q;
  assign eof         = eof_q;
  assign locked      = locked_q;
  assign inverted    = inverted_q;
  assign frame_count = frame_count_q;
  assign asm_err     = asm_err_q;

endmodule

// File: tb/tb_asm_frame_sync.sv
// Bench for asm_frame_sync: random bit streams checked against a window-search model of the framer.
module tb_asm_frame_sync;

  localparam logic [31:0] ASM         = 32'h1ACFFC1D;
  localparam int          FRAME_BYTES = 1020;
  localparam int          MAX_ERR     = 2;
  localparam int          LOCK_MISS   = 3;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic [7:0]  byte_out;
  logic        byte_valid, sof, eof, locked, inverted;
  logic [15:0] frame_count;
  logic [5:0]  asm_err;

  asm_frame_sync dut (
    .clk(clk), .sys_rst(sys_rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .byte_out(byte_out), .byte_valid(byte_valid), .sof(sof), .eof(eof),
    .locked(locked), .inverted(inverted), .frame_count(frame_count), .asm_err(asm_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] b; logic s; logic e; int idx; } bev_t;
  typedef struct { int idx; logic v; } lev_t;
  typedef struct { int idx; int d; } aev_t;

  int total = 0;
  int bad   = 0;
  int nbits = 0;
  int run_id = 0;
  int b_base = 0;
  int l_base = 0;

  bit   stream[$];
  bev_t exp_b[$], mon_b[$];
  lev_t exp_l[$], mon_l[$];
  aev_t exp_a[$];
  logic [5:0] asm_at[int];
  logic prev_locked = 1'b0;
  int   m_fc, m_err;
  bit   m_lock, m_inv;

  // Observer: samples 2 time units after each rising edge.
  always begin
    @(posedge clk);
    #2;
    if (byte_valid === 1'b1) mon_b.push_back('{byte_out, sof, eof, nbits});
    if (nbits > 0 && locked !== prev_locked) mon_l.push_back('{nbits, locked});
    prev_locked = locked;
    asm_at[run_id * 1000000 + nbits] = asm_err;
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_word(input logic [31:0] w);
    for (int k = 31; k >= 0; k--) stream.push_back(w[k]);
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) stream.push_back(b[k]);
  endtask

  task automatic push_frame_counting();
    for (int k = 0; k < FRAME_BYTES; k++) push_byte(8'(k % 256));
  endtask

  task automatic push_frame_random();
    for (int k = 0; k < FRAME_BYTES; k++) push_byte(8'($urandom_range(0, 255)));
  endtask

  // Called at posedge+1; leaves the bench at posedge+1.
  task automatic drive_stream(input int maxgap);
    foreach (stream[i]) begin
      bit_in    = stream[i];
      bit_valid = 1'b1;
      @(posedge clk); #1;
      nbits++;
      bit_valid = 1'b0;
      bit_in    = 1'b0;
      if (maxgap > 0) repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset(input logic vld_during_rst);
    @(posedge clk); #1;
    sys_rst   = 1'b1;
    bit_valid = vld_during_rst;
    bit_in    = 1'b1;
    @(posedge clk); #1;
    sys_rst   = 1'b0;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    run_id++;
    nbits  = 0;
    b_base = mon_b.size();
    l_base = mon_l.size();
    stream.delete();
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] win(input int last);
    logic [31:0] w;
    for (int k = 0; k < 32; k++) w[31-k] = stream[last-31+k];
    return w;
  endfunction

  // Walks the stream as: hunt for the earliest full 32-bit window that is a
  // marker in either polarity, then consume whole frames and trailing
  // markers until enough markers are missed in a row.
  task automatic model_run();
    int n, p, i, d, di, dd, misses;
    bit done, found;
    logic [7:0] v;
    n = stream.size(); p = 0; done = 0;
    exp_b.delete(); exp_l.delete(); exp_a.delete();
    m_fc = 0; m_err = 0; m_lock = 0; m_inv = 0;
    while (!done) begin
      i = p + 31; found = 0;
      while (i < n && !found) begin
        d  = $countones(win(i) ^ ASM);
        di = $countones(win(i) ^ ~ASM);
        if (d <= MAX_ERR) begin found = 1; m_inv = 0; m_err = d; end
        else if (di <= MAX_ERR) begin found = 1; m_inv = 1; m_err = di; end
        else i++;
      end
      if (!found) done = 1;
      else begin
        p = i + 1; m_lock = 1; misses = 0;
        exp_l.push_back('{p, 1'b1});
        exp_a.push_back('{p, m_err});
        while (!done && m_lock) begin
          for (int b = 0; b < FRAME_BYTES; b++) begin
            if (!done) begin
              if (p + 8 > n) done = 1;
              else begin
                for (int k = 0; k < 8; k++) v[7-k] = stream[p+k] ^ m_inv;
                exp_b.push_back('{v, (b == 0), (b == FRAME_BYTES-1), p + 8});
                p += 8;
              end
            end
          end
          if (!done) begin
            m_fc = (m_fc + 1) % 65536;
            if (p + 32 > n) done = 1;
            else begin
              dd = $countones(win(p + 31) ^ (m_inv ? ~ASM : ASM));
              p += 32; m_err = dd;
              exp_a.push_back('{p, dd});
              if (dd <= MAX_ERR) misses = 0;
              else begin
                misses++;
                if (misses == LOCK_MISS) begin
                  m_lock = 0; m_inv = 0;
                  exp_l.push_back('{p, 1'b0});
                end
              end
            end
          end
        end
      end
    end
  endtask

  // Index of first disagreement between observed and modelled lists, -1 if none.
  function automatic int byte_diff();
    int n = mon_b.size() - b_base;
    for (int i = 0; i < n && i < exp_b.size(); i++) begin
      if (mon_b[b_base+i].b !== exp_b[i].b || mon_b[b_base+i].s !== exp_b[i].s ||
          mon_b[b_base+i].e !== exp_b[i].e || mon_b[b_base+i].idx != exp_b[i].idx) return i;
    end
    if (n != exp_b.size()) return (n < exp_b.size()) ? n : exp_b.size();
    return -1;
  endfunction

  function automatic int lock_diff();
    int n = mon_l.size() - l_base;
    for (int i = 0; i < n && i < exp_l.size(); i++) begin
      if (mon_l[l_base+i].v !== exp_l[i].v || mon_l[l_base+i].idx != exp_l[i].idx) return i;
    end
    if (n != exp_l.size()) return (n < exp_l.size()) ? n : exp_l.size();
    return -1;
  endfunction

  function automatic int asm_diff();
    int key;
    foreach (exp_a[i]) begin
      key = run_id * 1000000 + exp_a[i].idx;
      if (!asm_at.exists(key)) return i;
      if (asm_at[key] !== 6'(exp_a[i].d)) return i;
    end
    return -1;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset(1'b0);
    total++;
    if ({byte_out, byte_valid, sof, eof, locked, inverted, frame_count, asm_err} !== 36'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0",
               {byte_out, byte_valid, sof, eof, locked, inverted, frame_count, asm_err});
    end
  endtask

  task automatic test_lock_plain();
    int r;
    do_reset(1'b0);
    push_word(ASM);
    push_frame_counting();
    drive_stream(3);
    model_run();
    total++; r = byte_diff();
    if (r !== -1) begin bad++; $display("FAIL plain_bytes at=%0d got_n=%0d want_n=%0d", r, mon_b.size()-b_base, exp_b.size()); end
    total++; r = lock_diff();
    if (r !== -1) begin bad++; $display("FAIL plain_lock at=%0d got_n=%0d want_n=%0d", r, mon_l.size()-l_base, exp_l.size()); end
    total++; r = asm_diff();
    if (r !== -1) begin bad++; $display("FAIL plain_asm_err eval=%0d want=%0d", r, exp_a[r].d); end
    total++;
    if ({locked, inverted, frame_count, asm_err} !== {m_lock, m_inv, 16'(m_fc), 6'(m_err)}) begin
      bad++; $display("FAIL plain_status got=%b/%b/%0d/%0d want=%b/%b/%0d/%0d",
                      locked, inverted, frame_count, asm_err, m_lock, m_inv, m_fc, m_err);
    end
    total++;
    if (mon_b.size() - b_base !== FRAME_BYTES || frame_count !== 16'd1) begin
      bad++; $display("FAIL plain_count got=%0d/%0d want=%0d/1", mon_b.size()-b_base, frame_count, FRAME_BYTES);
    end
  endtask

  task automatic test_lock_inverted();
    int r;
    do_reset(1'b0);
    push_word(~ASM);
    for (int k = 0; k < FRAME_BYTES; k++) push_byte(~8'(k % 256));
    drive_stream(0);
    model_run();
    total++; r = byte_diff();
    if (r !== -1) begin bad++; $display("FAIL inv_bytes at=%0d got_n=%0d want_n=%0d", r, mon_b.size()-b_base, exp_b.size()); end
    total++; r = lock_diff();
    if (r !== -1) begin bad++; $display("FAIL inv_lock at=%0d got_n=%0d want_n=%0d", r, mon_l.size()-l_base, exp_l.size()); end
    total++; r = asm_diff();
    if (r !== -1) begin bad++; $display("FAIL inv_asm_err eval=%0d want=%0d", r, exp_a[r].d); end
    total++;
    if ({locked, inverted, frame_count, asm_err} !== {m_lock, m_inv, 16'(m_fc), 6'(m_err)}) begin
      bad++; $display("FAIL inv_status got=%b/%b/%0d/%0d want=%b/%b/%0d/%0d",
                      locked, inverted, frame_count, asm_err, m_lock, m_inv, m_fc, m_err);
    end
    total++;
    if (inverted !== 1'b1 || mon_b.size() - b_base < 3 || mon_b[b_base+2].b !== 8'd2) begin
      bad++; $display("FAIL inv_polarity got_inv=%b want_inv=1", inverted);
    end
  endtask

  task automatic test_marker_errors();
    int r;
    // two bit errors: still a marker
    do_reset(1'b0);
    push_word(32'h1ACFFC1C ^ 32'h00000002);
    for (int k = 0; k < 16; k++) push_byte(8'($urandom_range(0, 255)));
    drive_stream(1);
    model_run();
    total++; r = byte_diff();
    if (r !== -1) begin bad++; $display("FAIL err2_bytes at=%0d got_n=%0d want_n=%0d", r, mon_b.size()-b_base, exp_b.size()); end
    total++; r = lock_diff();
    if (r !== -1) begin bad++; $display("FAIL err2_lock at=%0d got_n=%0d want_n=%0d", r, mon_l.size()-l_base, exp_l.size()); end
    total++;
    if (locked !== 1'b1 || asm_err !== 6'd2) begin
      bad++; $display("FAIL err2_status got=%b/%0d want=1/2", locked, asm_err);
    end
    // three bit errors: never a marker
    do_reset(1'b0);
    push_word(ASM ^ 32'h00000007);
    for (int k = 0; k < 40; k++) stream.push_back(1'b0);
    drive_stream(1);
    model_run();
    total++;
    if (locked !== m_lock || mon_b.size() - b_base !== exp_b.size()) begin
      bad++; $display("FAIL err3_nolock got=%b/%0d want=%b/%0d", locked, mon_b.size()-b_base, m_lock, exp_b.size());
    end
  endtask

  task automatic test_flywheel_and_loss();
    int r;
    do_reset(1'b0);
    push_word(ASM);           push_frame_random();
    push_word(32'h00000000);  push_frame_random();
    push_word(ASM);           push_frame_random();
    push_word(ASM ^ 32'h0F0F0F0F); push_frame_random();
    push_word(32'hFFFF0000);  push_frame_random();
    push_word(32'h00000000);
    for (int k = 0; k < 64; k++) stream.push_back(1'b0);
    drive_stream(0);
    model_run();
    total++; r = byte_diff();
    if (r !== -1) begin bad++; $display("FAIL fly_bytes at=%0d got_n=%0d want_n=%0d", r, mon_b.size()-b_base, exp_b.size()); end
    total++; r = lock_diff();
    if (r !== -1) begin bad++; $display("FAIL fly_lock at=%0d got_n=%0d want_n=%0d", r, mon_l.size()-l_base, exp_l.size()); end
    total++; r = asm_diff();
    if (r !== -1) begin bad++; $display("FAIL fly_asm_err eval=%0d want=%0d", r, exp_a[r].d); end
    total++;
    if ({locked, inverted, frame_count, asm_err} !== {m_lock, m_inv, 16'(m_fc), 6'(m_err)}) begin
      bad++; $display("FAIL fly_status got=%b/%b/%0d/%0d want=%b/%b/%0d/%0d",
                      locked, inverted, frame_count, asm_err, m_lock, m_inv, m_fc, m_err);
    end
    total++;
    if (frame_count !== 16'd5 || locked !== 1'b0 || mon_b.size() - b_base !== 5 * FRAME_BYTES) begin
      bad++; $display("FAIL fly_totals got=%0d/%b/%0d want=5/0/%0d", frame_count, locked, mon_b.size()-b_base, 5*FRAME_BYTES);
    end
  endtask

  task automatic test_reset_midframe();
    int r;
    do_reset(1'b0);
    push_word(ASM);
    for (int k = 0; k < 500; k++) push_byte(8'($urandom_range(0, 255)));
    for (int k = 0; k < 4; k++) stream.push_back(1'($urandom_range(0, 1)));
    drive_stream(0);
    model_run();
    total++; r = byte_diff();
    if (r !== -1) begin bad++; $display("FAIL mid_bytes at=%0d got_n=%0d want_n=%0d", r, mon_b.size()-b_base, exp_b.size()); end
    // reset with a coincident valid bit, which must be dropped
    do_reset(1'b1);
    total++;
    if ({byte_out, byte_valid, sof, eof, locked, inverted, frame_count, asm_err} !== 36'd0) begin
      bad++;
      $display("FAIL mid_reset_outputs got=%h want=0",
               {byte_out, byte_valid, sof, eof, locked, inverted, frame_count, asm_err});
    end
    for (int k = 0; k < 8; k++) stream.push_back(1'($urandom_range(0, 1)));
    push_word(ASM);
    for (int k = 0; k < 6; k++) push_byte(8'($urandom_range(0, 255)));
    drive_stream(1);
    model_run();
    total++; r = byte_diff();
    if (r !== -1) begin bad++; $display("FAIL relock_bytes at=%0d got_n=%0d want_n=%0d", r, mon_b.size()-b_base, exp_b.size()); end
    total++; r = lock_diff();
    if (r !== -1) begin bad++; $display("FAIL relock_lock at=%0d got_n=%0d want_n=%0d", r, mon_l.size()-l_base, exp_l.size()); end
    total++;
    if (locked !== 1'b1 || frame_count !== 16'd0) begin
      bad++; $display("FAIL relock_status got=%b/%0d want=1/0", locked, frame_count);
    end
  endtask

  initial begin
    test_reset();
    test_lock_plain();
    test_lock_inverted();
    test_marker_errors();
    test_flywheel_and_loss();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
